// File: rtl/clock_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// display_clock_pkg
// Shared types and constants for the clock/reset sequencer slice.
//   seq_state_t  : sequencer FSM state encoding
//   STATUS_CNT_W : width of the saturating status counters
// Build option: CLOCK_RESET_SEQ_STATUS_EN (used by the top, not here).
// -----------------------------------------------------------------------------
package display_clock_pkg;

  typedef enum logic [1:0] {
    SEQ_RESET_MMCM = 2'd0,
    SEQ_WAIT_LOCK  = 2'd1,
    SEQ_RELEASE    = 2'd2,
    SEQ_RUN        = 2'd3
  } seq_state_t;

  localparam int STATUS_CNT_W = 8;

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer_if
// Groups the sequencer's lock inputs and reset/status outputs.
//   locked_async : MMCM lock flags, asynchronous to the sequencer clock
//   mmcm_rst     : active-high reset to all MMCMs
//   chan_rstn    : per-domain active-low resets
//   all_ready    : high while every domain is out of reset and locked
//   retry_count  : saturating lock-timeout count
//   loss_count   : saturating lock-loss-in-service count
// Modports: master = the sequencer, slave = the clocking fabric / consumer.
// -----------------------------------------------------------------------------
interface clock_reset_sequencer_if
  import display_clock_pkg::*;
#(
  parameter int NUM_CHANNELS = 2
) ();

  logic [NUM_CHANNELS-1:0] locked_async;
  logic                    mmcm_rst;
  logic [NUM_CHANNELS-1:0] chan_rstn;
  logic                    all_ready;
  logic [STATUS_CNT_W-1:0] retry_count;
  logic [STATUS_CNT_W-1:0] loss_count;

  modport master (
    input  locked_async,
    output mmcm_rst,
    output chan_rstn,
    output all_ready,
    output retry_count,
    output loss_count
  );

  modport slave (
    output locked_async,
    input  mmcm_rst,
    input  chan_rstn,
    input  all_ready,
    input  retry_count,
    input  loss_count
  );

endinterface

// File: rtl/clock_reset_sequencer_lock_sync.sv
// -----------------------------------------------------------------------------
// lock_sync
// Multi-flop synchroniser bringing asynchronous lock flags into clk.
//   clk  : destination clock
//   rstn : synchronous active-low reset, clears every stage
//   d    : asynchronous input bits
//   q    : synchronised output bits (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module lock_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer
// Brings up a set of MMCMs and their downstream reset domains:
//   pulse mmcm_rst, wait for every lock, release domain resets one at a time
//   with a fixed gap, then report ready. Losing any lock while releasing or
//   running drops every domain back into reset and restarts the sequence.
// Ports:
//   clk  : single clock, all logic on posedge
//   rstn : synchronous active-low reset
//   bus  : clock_reset_sequencer_if.master (locked_async in; mmcm_rst,
//          chan_rstn, all_ready, retry_count, loss_count out)
// Build option: CLOCK_RESET_SEQ_STATUS_EN enables retry_count/loss_count;
//   without it both read as constant 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module clock_reset_sequencer
  import display_clock_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int RELEASE_GAP     = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  clock_reset_sequencer_if.master bus
);

  localparam logic [1:0] ST_RESET_MMCM = SEQ_RESET_MMCM;
  localparam logic [1:0] ST_WAIT_LOCK  = SEQ_WAIT_LOCK;
  localparam logic [1:0] ST_RELEASE    = SEQ_RELEASE;
  localparam logic [1:0] ST_RUN        = SEQ_RUN;

  // One timer serves all three timed phases, so size it for the longest.
  localparam int TMR_MAX0 = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_MAX  = (TMR_MAX0 > RELEASE_GAP) ? TMR_MAX0 : RELEASE_GAP;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  // idx counts 0..NUM_CHANNELS inclusive (NUM_CHANNELS = all released).
  localparam int IDX_W    = $clog2(NUM_CHANNELS + 1);

  logic [NUM_CHANNELS-1:0] lock_s;
  logic                    all_lock;
  logic                    timeout_hit;

  logic [1:0]              state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] chan_rstn_q, chan_rstn_d;
  logic                    mmcm_rst_q, mmcm_rst_d;
  logic                    all_ready_q, all_ready_d;

  // Lock synchronisation stage
  lock_sync #(
    .WIDTH  (NUM_CHANNELS),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.locked_async),
    .q    (lock_s)
  );

  assign all_lock    = &lock_s;
  assign timeout_hit = (timer_q == TMR_W'(LOCK_TIMEOUT - 1));

  // Sequencer next-state stage
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    chan_rstn_d = chan_rstn_q;

    case (state_q)
      ST_RESET_MMCM: begin
        chan_rstn_d = '0;
        idx_d       = '0;
        if (timer_q == TMR_W'(MMCM_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is tested before the timeout so a coincident lock wins.
        if (all_lock) begin
          state_d     = ST_RELEASE;
          timer_d     = '0;
          chan_rstn_d = NUM_CHANNELS'(1);
          idx_d       = IDX_W'(1);
        end else if (timeout_hit) begin
          state_d = ST_RESET_MMCM;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (!all_lock) begin
          state_d     = ST_RESET_MMCM;
          timer_d     = '0;
          idx_d       = '0;
          chan_rstn_d = '0;
        end else if (idx_q == IDX_W'(NUM_CHANNELS)) begin
          // Only reachable with a single channel: ready one cycle later.
          state_d = ST_RUN;
        end else if (timer_q == TMR_W'(RELEASE_GAP - 1)) begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              chan_rstn_d[i] = 1'b1;
            end
          end
          idx_d   = idx_q + 1'b1;
          timer_d = '0;
          // The last domain and all_ready come out together.
          if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
            state_d = ST_RUN;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!all_lock) begin
          state_d     = ST_RESET_MMCM;
          timer_d     = '0;
          idx_d       = '0;
          chan_rstn_d = '0;
        end
      end

      default: begin
        state_d     = ST_RESET_MMCM;
        timer_d     = '0;
        idx_d       = '0;
        chan_rstn_d = '0;
      end
    endcase

    // Outputs registered from the next state so they align with state_q.
    mmcm_rst_d  = (state_d == ST_RESET_MMCM);
    all_ready_d = (state_d == ST_RUN);
  end

  // Sequencer state register stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_RESET_MMCM;
      timer_q     <= '0;
      idx_q       <= '0;
      chan_rstn_q <= '0;
      mmcm_rst_q  <= 1'b1;
      all_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      chan_rstn_q <= chan_rstn_d;
      mmcm_rst_q  <= mmcm_rst_d;
      all_ready_q <= all_ready_d;
    end
  end

  assign bus.mmcm_rst  = mmcm_rst_q;
  assign bus.chan_rstn = chan_rstn_q;
  assign bus.all_ready = all_ready_q;

`ifdef CLOCK_RESET_SEQ_STATUS_EN
  function automatic logic [STATUS_CNT_W-1:0] sat_inc(input logic [STATUS_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic                    retry_inc, loss_inc;
  logic [STATUS_CNT_W-1:0] retry_count_q, retry_count_d;
  logic [STATUS_CNT_W-1:0] loss_count_q, loss_count_d;

  assign retry_inc = (state_q == ST_WAIT_LOCK) && !all_lock && timeout_hit;
  assign loss_inc  = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !all_lock;

  // Status counter stage
  always_comb begin
    retry_count_d = retry_inc ? sat_inc(retry_count_q) : retry_count_q;
    loss_count_d  = loss_inc  ? sat_inc(loss_count_q)  : loss_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      retry_count_q <= '0;
      loss_count_q  <= '0;
    end else begin
      retry_count_q <= retry_count_d;
      loss_count_q  <= loss_count_d;
    end
  end

  assign bus.retry_count = retry_count_q;
  assign bus.loss_count  = loss_count_q;
`else
  assign bus.retry_count = '0;
  assign bus.loss_count  = '0;
`endif

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of downstream reset domains/lock inputs (1-8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for lock inputs (2-4).
REQ-003 SHALL have parameter MMCM_RST_CYCLES, default 16: cycles mmcm_rst is held high per attempt (>=1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 100000: cycles allowed for all locks before retry (>=2).
REQ-005 SHALL have parameter RELEASE_GAP, default 8: cycles between successive channel reset releases (>=1).
REQ-006 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-007 SHALL have port rstn  input  1  reset; one clock, synchronous, active-low.
REQ-008 SHALL have port locked_async  input  NUM_CHANNELS  MMCM lock flags, asynchronous to clk.
REQ-009 SHALL have port mmcm_rst  output  1  active-high reset to all MMCMs.
REQ-010 SHALL have port chan_rstn  output  NUM_CHANNELS  per-domain active-low reset, registered.
REQ-011 SHALL have port all_ready  output  1  high only in RUN.
REQ-012 SHALL have port retry_count  output  8  saturating lock-timeout count.
REQ-013 SHALL have port loss_count  output  8  saturating lock-loss-in-service count.

Function
REQ-014 SHALL pass each locked_async bit through SYNC_STAGES flops; the FSM uses only synchronised lock_s.
REQ-015 SHALL implement FSM states RESET_MMCM, WAIT_LOCK, RELEASE, RUN.
REQ-016 RESET_MMCM SHALL drive mmcm_rst=1 for exactly MMCM_RST_CYCLES cycles, then enter WAIT_LOCK with timer cleared.
REQ-017 WAIT_LOCK SHALL drive mmcm_rst=0; all lock_s high -> RELEASE; else timer reaching LOCK_TIMEOUT-1 -> RESET_MMCM and retry_count+1.
REQ-018 Lock-complete and timeout in the same cycle SHALL resolve to RELEASE (lock wins, no retry increment).
REQ-019 RELEASE SHALL set chan_rstn[0]=1 the cycle after entry and chan_rstn[i]=1 exactly RELEASE_GAP cycles after chan_rstn[i-1]; once chan_rstn[NUM_CHANNELS-1] is released, the FSM enters RUN.
REQ-020 RUN SHALL assert all_ready=1 starting the cycle it is entered.
REQ-021 In RELEASE or RUN, any lock_s bit low SHALL clear all chan_rstn and all_ready on the next edge, increment loss_count, and enter RESET_MMCM.
REQ-022 Counters SHALL saturate at 255 and never wrap.
REQ-023 NUM_CHANNELS=1 SHALL go RELEASE->RUN the cycle after chan_rstn[0] rises.

Reset
REQ-024 rstn=0 at a clock edge SHALL force state RESET_MMCM, timers 0, mmcm_rst=1, chan_rstn=0, all_ready=0, retry_count=0, loss_count=0, synchroniser flops 0.
REQ-025 Reset mid-RELEASE or mid-RUN SHALL take effect at the next edge; after release the full sequence restarts from REQ-016.

Configuration
REQ-026 Macro CLOCK_RESET_SEQ_STATUS_EN defined: retry_count and loss_count SHALL be implemented per REQ-017/021/022.
REQ-027 Macro undefined: retry_count and loss_count SHALL be constant 0, no counter flops; sequencing behaviour unchanged.

Structure
REQ-028 Package display_clock_pkg SHALL hold the seq_state_t enum and STATUS_CNT_W=8 constant.
REQ-029 Sub-module lock_sync (parameters WIDTH, STAGES; ports clk, rstn, d, q) SHALL implement REQ-014.

Verification
REQ-030 Reset then lock all at cycle 40 (NUM_CHANNELS=2, defaults) -> mmcm_rst high 16 cycles; chan_rstn[0] rises 1 cycle after lock_s, chan_rstn[1] 8 later, all_ready the cycle chan_rstn[1] rises.
REQ-031 LOCK_TIMEOUT=50, never lock -> mmcm_rst re-pulses every 66 cycles; retry_count 1,2,3...; saturates at 255.
REQ-032 In RUN, drop locked_async[1] for 3 cycles -> all chan_rstn=0 and all_ready=0 within SYNC_STAGES+1 cycles; loss_count=1; mmcm_rst 16 cycles.
REQ-033 Lock asserted so lock_s rises exactly on timeout cycle -> RELEASE entered, retry_count unchanged.
REQ-034 rstn low for 1 cycle mid-RELEASE -> all outputs to reset values next edge; sequence restarts.
REQ-035 Build without CLOCK_RESET_SEQ_STATUS_EN, repeat REQ-031 -> retry_count stays 0, timing identical.
